axis_demux_2: RTL and testbench

- 1-to-2 AXI-Stream packet demultiplexer. It is the egress-side counterpart of the 2-requester round-robin arbiter/mux.
- A single upstream stream is steered to output port 0 or 1 by a 1-bit tdest sampled on the first beat of each packet.
- The route is held until tlast is accepted.
- Each output has a one-deep registered slot, so every output is registered and full throughput is sustained.

---
 rtl/axis_demux_2.sv | 190 +++++++++++++++++++
 tb/tb_axis_demux_2.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/axis_demux_2.sv
// 1-to-2 AXI-Stream packet demultiplexer: tdest on the first beat picks the port, held until tlast.
// Optional per-port packet counters are enabled with the AXIS_DEMUX_PKT_CNT_EN macro.
module axis_demux_2 #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              axis_clk,
    input  logic              axis_reset_n,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tdest,
    output logic [DATA_W-1:0] m0_axis_tdata,
    output logic              m0_axis_tvalid,
    input  logic              m0_axis_tready,
    output logic              m0_axis_tlast,
    output logic [DATA_W-1:0] m1_axis_tdata,
    output logic              m1_axis_tvalid,
    input  logic              m1_axis_tready,
    output logic              m1_axis_tlast,
    output logic              busy
`ifdef AXIS_DEMUX_PKT_CNT_EN
    ,
    output logic [CNT_W-1:0]  pkt_cnt0,
    output logic [CNT_W-1:0]  pkt_cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t              state_r;
    logic                busy_r;
    logic                tgt_s;
    logic                ready_s;
    logic                accept_s;
    logic                load0_s;
    logic                load1_s;
    logic                drain0_s;
    logic                drain1_s;
    logic                m0_valid_r;
    logic                m1_valid_r;
    logic                m0_last_r;
    logic                m1_last_r;
    logic [DATA_W-1:0]   m0_data_r;
    logic [DATA_W-1:0]   m1_data_r;

    // Target port: live tdest on a packet's first beat, the locked port afterwards.
    always_comb begin
        tgt_s = 1'b0;
        case (state_r)
            IDLE:    tgt_s = s_axis_tdest;
            LOCK0:   tgt_s = 1'b0;
            LOCK1:   tgt_s = 1'b1;
            default: tgt_s = 1'b0;
        endcase
    end

    // Upstream ready follows only the selected slot, so the other port never stalls us.
    always_comb begin
        ready_s = 1'b0;
        if (!axis_reset_n) begin
            ready_s = 1'b0;
        end else if (tgt_s) begin
            ready_s = !m1_valid_r || m1_axis_tready;
        end else begin
            ready_s = !m0_valid_r || m0_axis_tready;
        end
    end

    assign accept_s = s_axis_tvalid && ready_s;
    assign load0_s  = accept_s && !tgt_s;
    assign load1_s  = accept_s && tgt_s;
    assign drain0_s = m0_valid_r && m0_axis_tready;
    assign drain1_s = m1_valid_r && m1_axis_tready;

    // Packet lock state machine; busy is registered alongside the state.
    always_ff @(posedge axis_clk or negedge axis_reset_n) begin
        if (!axis_reset_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else if (accept_s) begin
            case (state_r)
                IDLE: begin
                    if (!s_axis_tlast) begin
                        state_r <= s_axis_tdest ? LOCK1 : LOCK0;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                LOCK0, LOCK1: begin
                    if (s_axis_tlast) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= state_r;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end else begin
            state_r <= state_r;
            busy_r  <= busy_r;
        end
    end

    // Port-0 output slot: a load wins over a drain, giving back-to-back beats without bubbles.
    always_ff @(posedge axis_clk or negedge axis_reset_n) begin
        if (!axis_reset_n) begin
            m0_valid_r <= 1'b0;
            m0_data_r  <= {DATA_W{1'b0}};
            m0_last_r  <= 1'b0;
        end else if (load0_s) begin
            m0_valid_r <= 1'b1;
            m0_data_r  <= s_axis_tdata;
            m0_last_r  <= s_axis_tlast;
        end else if (drain0_s) begin
            m0_valid_r <= 1'b0;
        end else begin
            m0_valid_r <= m0_valid_r;
        end
    end

    // Port-1 output slot, same rule as port 0.
    always_ff @(posedge axis_clk or negedge axis_reset_n) begin
        if (!axis_reset_n) begin
            m1_valid_r <= 1'b0;
            m1_data_r  <= {DATA_W{1'b0}};
            m1_last_r  <= 1'b0;
        end else if (load1_s) begin
            m1_valid_r <= 1'b1;
            m1_data_r  <= s_axis_tdata;
            m1_last_r  <= s_axis_tlast;
        end else if (drain1_s) begin
            m1_valid_r <= 1'b0;
        end else begin
            m1_valid_r <= m1_valid_r;
        end
    end

`ifdef AXIS_DEMUX_PKT_CNT_EN
    logic [CNT_W-1:0] cnt0_r;
    logic [CNT_W-1:0] cnt1_r;

    // Count completed packets per port on the tlast handshake; wraps naturally.
    always_ff @(posedge axis_clk or negedge axis_reset_n) begin
        if (!axis_reset_n) begin
            cnt0_r <= {CNT_W{1'b0}};
            cnt1_r <= {CNT_W{1'b0}};
        end else begin
            if (drain0_s && m0_last_r) begin
                cnt0_r <= cnt0_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt0_r <= cnt0_r;
            end
            if (drain1_s && m1_last_r) begin
                cnt1_r <= cnt1_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt1_r <= cnt1_r;
            end
        end
    end

    assign pkt_cnt0 = cnt0_r;
    assign pkt_cnt1 = cnt1_r;
`else
    if (CNT_W > 0) begin : g_no_pkt_cnt
    end
`endif

    assign s_axis_tready  = ready_s;
    assign m0_axis_tvalid = m0_valid_r;
    assign m0_axis_tdata  = m0_data_r;
    assign m0_axis_tlast  = m0_last_r;
    assign m1_axis_tvalid = m1_valid_r;
    assign m1_axis_tdata  = m1_data_r;
    assign m1_axis_tlast  = m1_last_r;
    assign busy           = busy_r;

endmodule

// File: tb/tb_axis_demux_2.sv
// Bench for axis_demux_2: directed vector table, then randomized traffic against a queue-based model.
module tb_axis_demux_2;

    localparam int DW = 32;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s_d = '0;
    logic          s_v = 1'b0;
    logic          s_r;
    logic          s_l = 1'b0;
    logic          s_dest = 1'b0;
    logic [DW-1:0] m0_d, m1_d;
    logic          m0_v, m1_v, m0_l, m1_l;
    logic          m0_r = 1'b1;
    logic          m1_r = 1'b1;
    logic          busy;
`ifdef AXIS_DEMUX_PKT_CNT_EN
    logic [CW-1:0] cnt0, cnt1;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    axis_demux_2 #(.DATA_W(DW), .CNT_W(CW)) dut (
        .axis_clk      (clk),
        .axis_reset_n  (rst_n),
        .s_axis_tdata  (s_d),
        .s_axis_tvalid (s_v),
        .s_axis_tready (s_r),
        .s_axis_tlast  (s_l),
        .s_axis_tdest  (s_dest),
        .m0_axis_tdata (m0_d),
        .m0_axis_tvalid(m0_v),
        .m0_axis_tready(m0_r),
        .m0_axis_tlast (m0_l),
        .m1_axis_tdata (m1_d),
        .m1_axis_tvalid(m1_v),
        .m1_axis_tready(m1_r),
        .m1_axis_tlast (m1_l),
        .busy          (busy)
`ifdef AXIS_DEMUX_PKT_CNT_EN
        ,
        .pkt_cnt0      (cnt0),
        .pkt_cnt1      (cnt1)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    typedef struct {
        logic v; logic [DW-1:0] d; logic l; logic dest; logic r0; logic r1;
        logic rdy;
        logic m0v; logic [DW-1:0] m0d; logic m0l;
        logic m1v; logic [DW-1:0] m1d; logic m1l;
        logic busy;
    } vec_t;

    function automatic vec_t mk(logic v, logic [DW-1:0] d, logic l, logic dest, logic r0, logic r1,
                                logic rdy, logic m0v, logic [DW-1:0] m0d, logic m0l,
                                logic m1v, logic [DW-1:0] m1d, logic m1l, logic b);
        vec_t x;
        x.v = v; x.d = d; x.l = l; x.dest = dest; x.r0 = r0; x.r1 = r1; x.rdy = rdy;
        x.m0v = m0v; x.m0d = m0d; x.m0l = m0l;
        x.m1v = m1v; x.m1d = m1d; x.m1l = m1l; x.busy = b;
        return x;
    endfunction

    typedef struct { logic [DW-1:0] d; logic l; } beat_t;

    task automatic do_reset();
        rst_n = 1'b0;
        s_v = 1'b1; s_d = 32'hDEAD_BEEF; s_l = 1'b0; s_dest = 1'b0;
        m0_r = 1'b1; m1_r = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("rst_s_tready", {63'd0, s_r}, 64'd0);
            check("rst_m0_tvalid", {63'd0, m0_v}, 64'd0);
            check("rst_m1_tvalid", {63'd0, m1_v}, 64'd0);
            check("rst_busy", {63'd0, busy}, 64'd0);
        end
        s_v = 1'b0;
        rst_n = 1'b1;
        #1;
        check("post_rst_m0_tvalid", {63'd0, m0_v}, 64'd0);
    endtask

    vec_t tbl[16];

    initial begin
        beat_t q0[$], q1[$];
        logic in_pkt, cur, dsel, exp_rdy, acc, hs0, hs1;
        logic [CW-1:0] mc0, mc1;

        // rows: inputs, then expected s_tready before the edge and outputs after it
        tbl[0]  = mk(1, 32'hA5, 1, 0, 1, 1,  1,  1, 32'hA5, 1,  0, 32'h0, 0,  0);
        tbl[1]  = mk(1, 32'h5A, 1, 1, 1, 1,  1,  0, 32'hA5, 1,  1, 32'h5A, 1, 0);
        tbl[2]  = mk(1, 32'h1, 0, 1, 1, 1,   1,  0, 32'hA5, 1,  1, 32'h1, 0,  1);
        tbl[3]  = mk(1, 32'h2, 0, 0, 1, 1,   1,  0, 32'hA5, 1,  1, 32'h2, 0,  1);
        tbl[4]  = mk(1, 32'h3, 0, 1, 1, 1,   1,  0, 32'hA5, 1,  1, 32'h3, 0,  1);
        tbl[5]  = mk(1, 32'h4, 1, 0, 1, 1,   1,  0, 32'hA5, 1,  1, 32'h4, 1,  0);
        tbl[6]  = mk(0, 32'h0, 0, 0, 1, 1,   1,  0, 32'hA5, 1,  0, 32'h4, 1,  0);
        tbl[7]  = mk(1, 32'hB1, 0, 0, 0, 1,  1,  1, 32'hB1, 0,  0, 32'h4, 1,  1);
        tbl[8]  = mk(1, 32'hB2, 0, 1, 0, 1,  0,  1, 32'hB1, 0,  0, 32'h4, 1,  1);
        tbl[9]  = mk(1, 32'hB2, 0, 1, 0, 1,  0,  1, 32'hB1, 0,  0, 32'h4, 1,  1);
        tbl[10] = mk(1, 32'hB2, 0, 1, 1, 1,  1,  1, 32'hB2, 0,  0, 32'h4, 1,  1);
        tbl[11] = mk(1, 32'hB3, 1, 1, 1, 1,  1,  1, 32'hB3, 1,  0, 32'h4, 1,  0);
        tbl[12] = mk(1, 32'hC1, 0, 1, 0, 1,  1,  1, 32'hB3, 1,  1, 32'hC1, 0, 1);
        tbl[13] = mk(1, 32'hC2, 0, 0, 0, 1,  1,  1, 32'hB3, 1,  1, 32'hC2, 0, 1);
        tbl[14] = mk(1, 32'hC3, 1, 0, 0, 1,  1,  1, 32'hB3, 1,  1, 32'hC3, 1, 0);
        tbl[15] = mk(0, 32'h0, 0, 0, 1, 1,   1,  0, 32'hB3, 1,  0, 32'hC3, 1, 0);

        do_reset();
        for (int i = 0; i < 16; i++) begin
            s_v = tbl[i].v; s_d = tbl[i].d; s_l = tbl[i].l; s_dest = tbl[i].dest;
            m0_r = tbl[i].r0; m1_r = tbl[i].r1;
            #1;
            check($sformatf("vec%0d_s_tready", i), {63'd0, s_r}, {63'd0, tbl[i].rdy});
            @(posedge clk); #1;
            check($sformatf("vec%0d_m0_tvalid", i), {63'd0, m0_v}, {63'd0, tbl[i].m0v});
            check($sformatf("vec%0d_m0_tdata", i), {32'd0, m0_d}, {32'd0, tbl[i].m0d});
            check($sformatf("vec%0d_m0_tlast", i), {63'd0, m0_l}, {63'd0, tbl[i].m0l});
            check($sformatf("vec%0d_m1_tvalid", i), {63'd0, m1_v}, {63'd0, tbl[i].m1v});
            check($sformatf("vec%0d_m1_tdata", i), {32'd0, m1_d}, {32'd0, tbl[i].m1d});
            check($sformatf("vec%0d_m1_tlast", i), {63'd0, m1_l}, {63'd0, tbl[i].m1l});
            check($sformatf("vec%0d_busy", i), {63'd0, busy}, {63'd0, tbl[i].busy});
        end

        // Randomized traffic: each port's queue models the content of its one-deep slot.
        do_reset();
        in_pkt = 1'b0; cur = 1'b0; mc0 = '0; mc1 = '0;
        for (int c = 0; c < 3000; c++) begin
            s_v = ($urandom_range(0, 9) < 7);
            s_d = $urandom;
            s_l = ($urandom_range(0, 3) == 0);
            s_dest = $urandom_range(0, 1);
            m0_r = ($urandom_range(0, 9) < 7);
            m1_r = ($urandom_range(0, 9) < 6);
            #1;
            dsel = in_pkt ? cur : s_dest;
            exp_rdy = dsel ? (q1.size() == 0 || m1_r) : (q0.size() == 0 || m0_r);
            check("rnd_s_tready", {63'd0, s_r}, {63'd0, exp_rdy});
            check("rnd_m0_tvalid", {63'd0, m0_v}, {63'd0, q0.size() != 0});
            check("rnd_m1_tvalid", {63'd0, m1_v}, {63'd0, q1.size() != 0});
            if (q0.size() != 0) begin
                check("rnd_m0_tdata", {32'd0, m0_d}, {32'd0, q0[0].d});
                check("rnd_m0_tlast", {63'd0, m0_l}, {63'd0, q0[0].l});
            end
            if (q1.size() != 0) begin
                check("rnd_m1_tdata", {32'd0, m1_d}, {32'd0, q1[0].d});
                check("rnd_m1_tlast", {63'd0, m1_l}, {63'd0, q1[0].l});
            end
            acc = s_v && exp_rdy;
            hs0 = (q0.size() != 0) && m0_r;
            hs1 = (q1.size() != 0) && m1_r;
            if (hs0) begin
                if (q0[0].l) mc0 = mc0 + 1'b1;
                void'(q0.pop_front());
            end
            if (hs1) begin
                if (q1[0].l) mc1 = mc1 + 1'b1;
                void'(q1.pop_front());
            end
            if (acc) begin
                if (dsel) q1.push_back('{s_d, s_l});
                else      q0.push_back('{s_d, s_l});
                if (s_l) in_pkt = 1'b0;
                else begin in_pkt = 1'b1; cur = dsel; end
            end
            @(posedge clk); #1;
            check("rnd_busy", {63'd0, busy}, {63'd0, in_pkt});
`ifdef AXIS_DEMUX_PKT_CNT_EN
            check("rnd_pkt_cnt0", {62'd0, cnt0}, {62'd0, mc0});
            check("rnd_pkt_cnt1", {62'd0, cnt1}, {62'd0, mc1});
`endif
        end

`ifdef AXIS_DEMUX_PKT_CNT_EN
        // Five single-beat packets to port 0 walk the 2-bit counter through its wrap.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            logic [CW-1:0] e;
            e = CW'(k + 1);
            s_v = 1'b1; s_d = 32'(k); s_l = 1'b1; s_dest = 1'b0; m0_r = 1'b1; m1_r = 1'b1;
            @(posedge clk); #1;
            s_v = 1'b0;
            @(posedge clk); #1;
            check($sformatf("cnt_seq%0d_pkt_cnt0", k), {62'd0, cnt0}, {62'd0, e});
            check($sformatf("cnt_seq%0d_pkt_cnt1", k), {62'd0, cnt1}, 64'd0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
